line_buffer: RTL and testbench

Raster-to-column converter feeding the kernel window stage of the HOG pipeline. Accepts one pixel per handshake in raster order and stores the previous BLOCK_HEIGHT-1 image rows. Once enough rows are buffered, it emits one vertically aligned column of BLOCK_HEIGHT pixels per accepted pixel on the per-row valid/ready bus that the kernel shift registers consume. It tracks frame position internally and restarts buffering at every frame boundary.

---
 rtl/hog_pkg.sv | 20 ++
 rtl/line_buffer_if.sv | 29 ++
 rtl/line_mem.sv | 26 ++
 rtl/line_buffer.sv | 139 +++++++++++++
 tb/tb_line_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hog_pkg.sv
// Shared types and helpers for the HOG front end: line buffer FSM encoding,
// default geometry and counter-width helper.
package hog_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_e;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_BLOCK_HEIGHT = 3;
    localparam int DEF_IMAGE_WIDTH  = 64;
    localparam int DEF_IMAGE_HEIGHT = 48;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_if.sv
// Pixel-in / column-out handshake bundle between the raster source, the line
// buffer and the kernel window shift registers.
interface line_buffer_if
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT
);
    localparam int OUTPUT_WIDTH = DATA_WIDTH * BLOCK_HEIGHT;

    logic [DATA_WIDTH-1:0]   in_pixel;
    logic                    in_valid;
    logic                    in_ready;
    logic [OUTPUT_WIDTH-1:0] out_pixels;
    logic [BLOCK_HEIGHT-1:0] out_valid;
    logic [BLOCK_HEIGHT-1:0] out_ready;
    logic                    frame_done;

    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, out_pixels, out_valid, frame_done
    );

    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, out_pixels, out_valid, frame_done
    );

endinterface

// File: rtl/line_mem.sv
// One image row of pixel storage: combinational read, synchronous write,
// both at the same address (the current column).
module line_mem
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IMAGE_WIDTH
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [cnt_width(DEPTH)-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer.sv
// Raster-to-column converter: keeps BLOCK_HEIGHT-1 previous rows and emits one
// vertical column per accepted pixel once enough rows of the frame are stored.
module line_buffer
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int OUTPUT_WIDTH = DATA_WIDTH * BLOCK_HEIGHT
) (
    input  logic          clk,
    input  logic          rst,
    line_buffer_if.slave  bus
);

    localparam int COL_W = cnt_width(IMAGE_WIDTH);
    localparam int ROW_W = cnt_width(IMAGE_HEIGHT);
    localparam int NMEM  = BLOCK_HEIGHT - 1;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(BLOCK_HEIGHT - 2);

    lb_state_e               state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic                    valid_q, valid_d;
    logic [OUTPUT_WIDTH-1:0] pix_q, pix_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;

    logic                    in_ready;
    logic                    in_fire;
    logic                    out_fire;
    logic                    load;
    logic                    col_end;
    logic                    frame_end;
    logic [DATA_WIDTH-1:0]   rd_data [NMEM];
    logic [DATA_WIDTH-1:0]   wr_data [NMEM];
    logic [OUTPUT_WIDTH-1:0] column;

    assign out_fire  = valid_q & (&bus.out_ready);
    assign in_ready  = (state_q == FILL) | ~valid_q | out_fire;
    assign in_fire   = bus.in_valid & in_ready;
    assign col_end   = (col_q == COL_LAST);
    assign frame_end = col_end & (row_q == ROW_LAST);
    assign load      = in_fire & (state_q == STREAM);

    // Each row shifts one memory up on every accept; the newest pixel enters
    // the top memory and also forms the bottom slice of the outgoing column.
    generate
        for (genvar gi = 0; gi < NMEM; gi++) begin : g_mem
            line_mem #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (IMAGE_WIDTH)
            ) u_line_mem (
                .clk   (clk),
                .we    (in_fire),
                .addr  (col_q),
                .wdata (wr_data[gi]),
                .rdata (rd_data[gi])
            );

            if (gi < NMEM - 1) begin : g_shift
                assign wr_data[gi] = rd_data[gi+1];
            end else begin : g_newest
                assign wr_data[gi] = bus.in_pixel;
            end

            assign column[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data[gi];
        end
    endgenerate

    assign column[OUTPUT_WIDTH-1 -: DATA_WIDTH] = bus.in_pixel;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_fire) begin
            if (col_end) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            case (state_q)
                FILL:    if (col_end && (row_q == ROW_FILL_LAST)) state_d = STREAM;
                STREAM:  if (frame_end) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // The output stage drains independently of the FSM, so the final column of
    // a frame can still be waiting while the next frame is filling.
    always_comb begin
        valid_d = valid_q;
        pix_d   = pix_q;
        last_d  = last_q;
        done_d  = out_fire & last_q;
        if (out_fire) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            pix_d   = column;
            last_d  = frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            pix_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_pixels = pix_q;
    assign bus.out_valid  = {BLOCK_HEIGHT{valid_q}};
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer on a 4x4 frame with 3-row columns;
// pixel value = row*16 + col.
module tb_line_buffer;

    localparam int DW = 8;
    localparam int BH = 3;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int OW = DW * BH;

    typedef struct packed {
        logic [OW-1:0] col;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    line_buffer_if #(.DATA_WIDTH(DW), .BLOCK_HEIGHT(BH)) bus ();

    line_buffer #(
        .DATA_WIDTH   (DW),
        .BLOCK_HEIGHT (BH),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .OUTPUT_WIDTH (OW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fires = 0;
    int   fd_seen = 0;
    int   first_fire_cyc = -1;
    int   last_fire_cyc = -1;
    logic fd_exp = 1'b0;
    int   tb_row = 0;
    int   tb_col = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    function automatic logic [OW-1:0] exp_col(input int r, input int c);
        return {pix(r, c), pix(r - 1, c), pix(r - 2, c)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected column per transfer, tracks frame_done.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            check("frame_done", OW'(bus.frame_done), OW'(fd_exp));
            if (bus.frame_done) fd_seen++;
            fd_exp = 1'b0;
            if ((&bus.out_valid) && (&bus.out_ready)) begin
                fires++;
                if (first_fire_cyc < 0) first_fire_cyc = cyc;
                last_fire_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_column: got %h required none", bus.out_pixels);
                end else begin
                    e = exp_q.pop_front();
                    check("column", bus.out_pixels, e.col);
                    fd_exp = e.last;
                end
            end
        end
    end

    // Offer the next raster pixel; returns at posedge+1 of the accepting cycle.
    task automatic send(input bit chk_fill);
        int waited = 0;
        bus.in_pixel = pix(tb_row, tb_col);
        bus.in_valid = 1'b1;
        @(negedge clk);
        if (chk_fill) begin
            check("fill_out_valid", OW'(bus.out_valid), OW'(3'b000));
            check("fill_in_ready", OW'(bus.in_ready), OW'(1'b1));
        end
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 for pixel (%0d,%0d)", tb_row, tb_col);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (tb_row >= BH - 1) begin
            exp_q.push_back('{col: exp_col(tb_row, tb_col),
                              last: (tb_row == IH - 1) && (tb_col == IW - 1)});
        end
        if (tb_col == IW - 1) begin
            tb_col = 0;
            tb_row = (tb_row == IH - 1) ? 0 : tb_row + 1;
        end else begin
            tb_col++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic fill();
        repeat (2 * IW) send(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int fires0;
        bus.in_pixel  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 3'b111;

        // Reset state
        #1 rst = 1'b0;
        #1;
        check("reset_out_valid", OW'(bus.out_valid), OW'(3'b000));
        check("reset_out_pixels", bus.out_pixels, '0);
        check("reset_frame_done", OW'(bus.frame_done), OW'(1'b0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_in_ready", OW'(bus.in_ready), OW'(1'b1));
        @(posedge clk);
        #1;

        // Fill rows 0-1
        fill();

        // First column appears one cycle after pixel 0x20 is accepted
        send(1'b0);
        @(negedge clk);
        check("first_col_valid", OW'(bus.out_valid), OW'(3'b111));
        check("first_col_pixels", bus.out_pixels, 24'h201000);
        @(posedge clk);
        #1;

        // Backpressure with partial ready
        bus.out_ready = 3'b101;
        send(1'b0);
        bus.in_pixel = pix(tb_row, tb_col);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_pixels", bus.out_pixels, 24'h211101);
            check("bp_valid", OW'(bus.out_valid), OW'(3'b111));
            check("bp_in_ready", OW'(bus.in_ready), OW'(1'b0));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 3'b111;
        repeat (6) send(1'b0);
        idle(3);
        check("frame1_done_count", OW'(fd_seen), OW'(1));

        // Frame 2: fill, then full-throughput rows 2-3
        fill();
        fires0 = fires;
        first_fire_cyc = -1;
        repeat (2 * IW) send(1'b0);
        @(negedge clk);
        check("tput_last_col", bus.out_pixels, 24'h332313);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("tput_frame_done", OW'(bus.frame_done), OW'(1'b1));
        @(posedge clk);
        #1;
        idle(2);
        check("tput_col_count", OW'(fires - fires0), OW'(8));
        check("tput_span", OW'(last_fire_cyc - first_fire_cyc), OW'(7));
        check("frame2_done_count", OW'(fd_seen), OW'(2));

        // Frame 3: wrap produces no output for 8 pixels, then (2,0) again
        fill();
        send(1'b0);
        @(negedge clk);
        check("wrap_first_col", bus.out_pixels, 24'h201000);
        @(posedge clk);
        #1;
        repeat (5) send(1'b0);

        // Reset mid row 3 with a column in flight
        rst = 1'b0;
        exp_q.delete();
        fd_exp = 1'b0;
        #1;
        check("midrst_out_valid", OW'(bus.out_valid), OW'(3'b000));
        check("midrst_frame_done", OW'(bus.frame_done), OW'(1'b0));
        check("midrst_out_pixels", bus.out_pixels, '0);
        tb_row = 0;
        tb_col = 0;
        idle(1);
        rst = 1'b1;
        fill();
        @(negedge clk);
        check("postrst_out_valid", OW'(bus.out_valid), OW'(3'b000));
        @(posedge clk);
        #1;
        send(1'b0);
        @(negedge clk);
        check("postrst_first_col", bus.out_pixels, 24'h201000);
        @(posedge clk);
        #1;
        idle(3);
        check("queue_drained", OW'(exp_q.size()), OW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no completion required finish before 20000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
